// File: rtl/cmsdk_fpga_sram_arb_pkg.sv
// Shared constants for the two-port SRAM arbiter: port indices and a helper
// that sizes the DMA starvation counter from its saturation value.
package cmsdk_fpga_sram_arb_pkg;

    localparam int   NUM_PORTS = 2;
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Enough bits to hold 0..max_val inclusive; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_arb.sv
// Two-requester arbiter in front of a single-port SRAM: CPU port has fixed
// priority, DMA port wins once after STARVE_MAX lost cycles; read-to-write turnaround enforced.
module cmsdk_fpga_sram_arb
    import cmsdk_fpga_sram_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          P0_REQ,
    input  logic          P0_WRITE,
    input  logic [AW-3:0] P0_ADDR,
    input  logic [31:0]   P0_WDATA,
    input  logic [3:0]    P0_BE,
    output logic          P0_GNT,
    output logic          P0_RVALID,
    output logic [31:0]   P0_RDATA,
    input  logic          P1_REQ,
    input  logic          P1_WRITE,
    input  logic [AW-3:0] P1_ADDR,
    input  logic [31:0]   P1_WDATA,
    input  logic [3:0]    P1_BE,
    output logic          P1_GNT,
    output logic          P1_RVALID,
    output logic [31:0]   P1_RDATA,
    output logic          SRAM_CS,
    output logic [AW-3:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    output logic [3:0]    SRAM_WREN,
    input  logic [31:0]   SRAM_RDATA
);

    localparam int            CW             = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] STARVE_CNT_MAX = CW'(STARVE_MAX);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] write;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] rvalid;
    logic [AW-3:0]        addr  [NUM_PORTS];
    logic [31:0]          wdata [NUM_PORTS];
    logic [3:0]           be    [NUM_PORTS];
    logic [31:0]          rdata [NUM_PORTS];

    logic          rd_pend_reg,    rd_pend_next;
    logic          rd_owner_reg,   rd_owner_next;
    logic [CW-1:0] starve_cnt_reg, starve_cnt_next;

    logic          win_valid;
    logic          win_idx;
    logic          win_write;

    assign req   = {P1_REQ,   P0_REQ};
    assign write = {P1_WRITE, P0_WRITE};

    assign addr[PORT_CPU]  = P0_ADDR;
    assign addr[PORT_DMA]  = P1_ADDR;
    assign wdata[PORT_CPU] = P0_WDATA;
    assign wdata[PORT_DMA] = P1_WDATA;
    assign be[PORT_CPU]    = P0_BE;
    assign be[PORT_DMA]    = P1_BE;

    // A write is held off for the one cycle in which read data is on the SRAM bus.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign elig[gi]   = req[gi] & ~(write[gi] & rd_pend_reg);
            assign gnt[gi]    = win_valid & (win_idx == 1'(gi));
            assign rvalid[gi] = ~RESET & rd_pend_reg & (rd_owner_reg == 1'(gi));
            assign rdata[gi]  = rvalid[gi] ? SRAM_RDATA : 32'h0;
        end
    endgenerate

    always_comb begin
        win_valid = 1'b0;
        win_idx   = PORT_CPU;
        if (!RESET) begin
            if (elig[PORT_DMA] && (starve_cnt_reg == STARVE_CNT_MAX)) begin
                win_valid = 1'b1;
                win_idx   = PORT_DMA;
            end else if (elig[PORT_CPU]) begin
                win_valid = 1'b1;
                win_idx   = PORT_CPU;
            end else if (elig[PORT_DMA]) begin
                win_valid = 1'b1;
                win_idx   = PORT_DMA;
            end
        end
    end

    assign win_write = write[win_idx];

    // The granted request is issued to the SRAM in the same cycle; the bus is
    // zeroed when idle so that stale fields never reach the memory.
    assign SRAM_CS    = win_valid;
    assign SRAM_ADDR  = win_valid ? addr[win_idx]  : '0;
    assign SRAM_WDATA = win_valid ? wdata[win_idx] : 32'h0;
    assign SRAM_WREN  = (win_valid && win_write) ? be[win_idx] : 4'h0;

    assign P0_GNT    = gnt[PORT_CPU];
    assign P1_GNT    = gnt[PORT_DMA];
    assign P0_RVALID = rvalid[PORT_CPU];
    assign P1_RVALID = rvalid[PORT_DMA];
    assign P0_RDATA  = rdata[PORT_CPU];
    assign P1_RDATA  = rdata[PORT_DMA];

    always_comb begin
        rd_pend_next    = win_valid & ~win_write;
        rd_owner_next   = rd_owner_reg;
        starve_cnt_next = starve_cnt_reg;
        if (win_valid && !win_write) begin
            rd_owner_next = win_idx;
        end
        // Any cycle the DMA port asks and loses counts, including turnaround stalls.
        if (gnt[PORT_DMA] || !req[PORT_DMA]) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_CNT_MAX) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= PORT_CPU;
            starve_cnt_reg <= '0;
        end else begin
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule
